data_ram_bank: RTL and testbench

- Byte-enabled, 256-bit-wide synchronous data memory bank.
- Sits directly downstream of the MEM-stage data aligner and consumes its rden/wren/ip_address/byteena/writeData. Returns the line-read data as readData, one cycle after the request.
- Adds read-during-write merging, sticky out-of-range error reporting and a read-valid strobe.

---
 rtl/data_ram_bank_if.sv | 25 ++
 rtl/data_ram_bank.sv | 84 ++++++++
 tb/tb_data_ram_bank.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_bank_if.sv
// Request/response bundle between the MEM-stage aligner (master) and the data RAM bank (slave).
interface data_ram_bank_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned V      = 256
);
  logic              rden;
  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [V/8-1:0]    byteena;
  logic [V-1:0]      data;
  logic              err_clr;
  logic [V-1:0]      q;
  logic              q_valid;
  logic              oor_err;

  modport master (
    output rden, wren, address, byteena, data, err_clr,
    input  q, q_valid, oor_err
  );

  modport slave (
    input  rden, wren, address, byteena, data, err_clr,
    output q, q_valid, oor_err
  );
endinterface

// File: rtl/data_ram_bank.sv
// Byte-enabled 256-bit line memory with 1-cycle registered reads, read-during-write merging
// and sticky out-of-range error. Optional access counters under DATA_RAM_BANK_STATS_EN.
module data_ram_bank #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned V      = 256
) (
  input  logic                clk,
  input  logic                reset,
  data_ram_bank_if.slave      bus
`ifdef DATA_RAM_BANK_STATS_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
`endif
);

  localparam int unsigned LANES   = V / 8;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [V-1:0] mem [DEPTH];

  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic [V-1:0]     old_line_c;
  logic [V-1:0]     rd_line_c;
  logic             rd_hit_c;
  logic             wr_hit_c;
  logic             oor_c;

  // Address decode and same-cycle write forwarding into the read path
  always_comb begin
    in_range_c = ({1'b0, bus.address} < DEPTH_L);
    idx_c      = bus.address[IDX_W-1:0];
    old_line_c = mem[idx_c];
    rd_hit_c   = bus.rden & in_range_c;
    wr_hit_c   = bus.wren & in_range_c;
    oor_c      = (bus.rden | bus.wren) & ~in_range_c;
    rd_line_c  = old_line_c;
    if (wr_hit_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (bus.byteena[i]) rd_line_c[8*i +: 8] = bus.data[8*i +: 8];
      end
    end
  end

  // Array is intentionally not reset; only in-range writes touch it
  always_ff @(posedge clk) begin
    if (wr_hit_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (bus.byteena[i]) mem[idx_c][8*i +: 8] <= bus.data[8*i +: 8];
      end
    end
  end

  // Read data, valid strobe and sticky error (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.oor_err <= 1'b0;
    end else begin
      bus.q_valid <= bus.rden;
      if (bus.rden) bus.q <= in_range_c ? rd_line_c : '0;
      if (oor_c)             bus.oor_err <= 1'b1;
      else if (bus.err_clr)  bus.oor_err <= 1'b0;
    end
  end

`ifdef DATA_RAM_BANK_STATS_EN
  // Saturating counters of accepted in-range accesses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_hit_c && (rd_count != 32'hFFFF_FFFF)) rd_count <= rd_count + 32'd1;
      if (wr_hit_c && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_bank.sv
// Self-checking bench for data_ram_bank: directed scenarios followed by random traffic
// compared against a line-level reference model.
module tb_data_ram_bank;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned V      = 256;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  data_ram_bank_if #(.ADDR_W(ADDR_W), .V(V)) bus ();

`ifdef DATA_RAM_BANK_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  data_ram_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .V(V)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
  );
`else
  data_ram_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .V(V)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lines as an associative array; writes apply before the read sees the line
  logic [V-1:0] m_mem [int];
  logic [V-1:0] m_q;
  logic         m_qv;
  logic         m_err;
  int           m_rd;
  int           m_wr;

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_qv = 1'b0; m_err = 1'b0; m_rd = 0; m_wr = 0;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input int addr,
                            input logic [31:0] be, input logic [V-1:0] dat, input logic clr);
    logic         inr;
    logic [V-1:0] line;
    inr = (addr < int'(DEPTH));
    if (wr && inr) begin
      line = m_mem.exists(addr) ? m_mem[addr] : '0;
      for (int i = 0; i < 32; i++) if (be[i]) line[8*i +: 8] = dat[8*i +: 8];
      m_mem[addr] = line;
      if (m_wr != -1) m_wr++;
    end
    m_qv = rd;
    if (rd) begin
      m_q = inr ? m_mem[addr] : '0;
      if (inr) m_rd++;
    end
    if ((rd || wr) && !inr) m_err = 1'b1;
    else if (clr)           m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".q"},       bus.q,             m_q);
    chk({tag, ".q_valid"}, V'(bus.q_valid),   V'(m_qv));
    chk({tag, ".oor_err"}, V'(bus.oor_err),   V'(m_err));
`ifdef DATA_RAM_BANK_STATS_EN
    chk({tag, ".rd_count"}, V'(rd_count), V'(m_rd));
    chk({tag, ".wr_count"}, V'(wr_count), V'(m_wr));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cycle(input string tag, input logic rd, input logic wr, input int addr,
                       input logic [31:0] be, input logic [V-1:0] dat, input logic clr);
    bus.rden    = rd;
    bus.wren    = wr;
    bus.address = ADDR_W'(addr);
    bus.byteena = be;
    bus.data    = dat;
    bus.err_clr = clr;
    @(posedge clk);
    model_edge(rd, wr, addr, be, dat, clr);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 0, 32'h0, '0, 1'b0);
  endtask

  function automatic logic [V-1:0] rand_line();
    logic [V-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [V-1:0] exp_line;
    logic [V-1:0] x_line;
    logic [V-1:0] y_line;
    int           addr;
    int           r;
    logic [31:0]  be;
    logic         rd;
    logic         wr;
    logic         clr;

    n_tests = 0;
    n_fail  = 0;
    bus.rden = 1'b0; bus.wren = 1'b0; bus.address = '0; bus.byteena = '0;
    bus.data = '0; bus.err_clr = 1'b0;
    model_reset();

    reset = 1'b1;
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    idle("post_reset");

    // Preload a pool of lines used by the random phase
    for (int a = 0; a < 16; a++) cycle("init", 1'b0, 1'b1, a, 32'hFFFF_FFFF, rand_line(), 1'b0);
    cycle("init", 1'b0, 1'b1, 1023, 32'hFFFF_FFFF, rand_line(), 1'b0);

    // Full write then read
    cycle("full_wr", 1'b0, 1'b1, 5, 32'hFFFF_FFFF, {32{8'hA5}}, 1'b0);
    cycle("full_rd", 1'b1, 1'b0, 5, 32'h0, '0, 1'b0);
    chk("full_rd.const", bus.q, {32{8'hA5}});

    // Partial byte write: bytes 4..19
    cycle("part_pre", 1'b0, 1'b1, 7, 32'hFFFF_FFFF, '0, 1'b0);
    cycle("part_wr", 1'b0, 1'b1, 7, 32'h000F_FFF0, {32{8'hFF}}, 1'b0);
    cycle("part_rd", 1'b1, 1'b0, 7, 32'h0, '0, 1'b0);
    exp_line = '0;
    for (int i = 4; i <= 19; i++) exp_line[8*i +: 8] = 8'hFF;
    chk("part_rd.const", bus.q, exp_line);

    // No-op write with zero byte enables
    cycle("noop_wr", 1'b0, 1'b1, 7, 32'h0, {32{8'h5A}}, 1'b0);
    cycle("noop_rd", 1'b1, 1'b0, 7, 32'h0, '0, 1'b0);

    // Read-during-write to the same line
    cycle("rdw_pre", 1'b0, 1'b1, 9, 32'hFFFF_FFFF, {32{8'h11}}, 1'b0);
    cycle("rdw", 1'b1, 1'b1, 9, 32'h0000_0003, {32{8'h22}}, 1'b0);
    chk("rdw.const", bus.q, {{30{8'h11}}, {2{8'h22}}});
    cycle("rdw_reread", 1'b1, 1'b0, 9, 32'h0, '0, 1'b0);
    chk("rdw_reread.const", bus.q, {{30{8'h11}}, {2{8'h22}}});

    // Back-to-back unaligned pair, then back-to-back reads
    x_line = rand_line();
    y_line = rand_line();
    cycle("pair_wr3", 1'b0, 1'b1, 3, 32'hFFFF_0000, x_line, 1'b0);
    cycle("pair_wr4", 1'b0, 1'b1, 4, 32'h0000_FFFF, y_line, 1'b0);
    cycle("pair_rd3", 1'b1, 1'b0, 3, 32'h0, '0, 1'b0);
    cycle("pair_rd4", 1'b1, 1'b0, 4, 32'h0, '0, 1'b0);

    // Out of range read, sticky error, clear, and set-wins with suppressed write
    cycle("oor_rd", 1'b1, 1'b0, 1024, 32'h0, '0, 1'b0);
    chk("oor_rd.q0", bus.q, '0);
    idle("oor_hold");
    idle("oor_hold2");
    cycle("oor_clr", 1'b0, 1'b0, 0, 32'h0, '0, 1'b1);
    cycle("oor_setwins", 1'b0, 1'b1, 1029, 32'hFFFF_FFFF, {32{8'h77}}, 1'b1);
    chk("oor_setwins.err", V'(bus.oor_err), V'(1'b1));
    cycle("oor_unchanged5", 1'b1, 1'b0, 5, 32'h0, '0, 1'b0);
    cycle("oor_unchanged0", 1'b1, 1'b0, 0, 32'h0, '0, 1'b0);
    cycle("oor_clr2", 1'b0, 1'b0, 0, 32'h0, '0, 1'b1);

    // Async reset between a read edge and the following edge
    cycle("prereset_rd", 1'b1, 1'b0, 5, 32'h0, '0, 1'b0);
    cycle("prereset_oor", 1'b1, 1'b0, 2000, 32'h0, '0, 1'b0);
    bus.address = ADDR_W'(5);
    bus.rden    = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 5, 32'h0, '0, 1'b0);
    #1;
    chk("midread.q_before", bus.q, {32{8'hA5}});
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    bus.rden = 1'b0;
    #2;
    reset = 1'b0;
    idle("after_reset");
    cycle("after_reset_rd", 1'b1, 1'b0, 5, 32'h0, '0, 1'b0);
    chk("after_reset_rd.const", bus.q, {32{8'hA5}});

    // Random traffic over a small line pool plus out-of-range addresses
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 21));
      if (r < 16)       addr = r;
      else if (r == 16) addr = 1023;
      else if (r == 17) addr = 1024;
      else if (r == 18) addr = 1500;
      else if (r == 19) addr = 16383;
      else              addr = int'($urandom_range(0, 15));
      rd  = ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       be = 32'hFFFF_FFFF;
        1:       be = 32'h0;
        default: be = $urandom;
      endcase
      cycle("rand", rd, wr, addr, be, rand_line(), clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
